// File: rtl/sys_ctrl.sv
// sys_ctrl: command controller between the RX byte synchronizer, the register
// file, the ALU and the TX byte path.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for a command byte (0xAA/0xBB/0xCC/0xDD)
// WR_ADDR  | write: waiting for the address byte
// WR_DATA  | write: waiting for the data byte, then one RF_WrEn pulse
// RD_ADDR  | read: waiting for the address byte, then one RF_RdEn pulse
// RD_WAIT  | read: waiting for RF_RdData_VLD
// ALU_A    | ALU: operand A byte, written to RF address 0
// ALU_B    | ALU: operand B byte, written to RF address 1
// ALU_FN   | ALU: function byte, then one ALU_EN pulse
// ALU_WAIT | ALU: waiting for ALU_OUT_VLD
// TX_LO    | presenting the low (or only) result byte to TX
// TX_HI    | presenting the high result byte to TX
module sys_ctrl #(
   parameter int Width = 8,
   parameter int AddrW = 4
) (
   input  logic               CLK,
   input  logic               Reset,
   input  logic [Width-1:0]   RX_P_DATA,
   input  logic               RX_D_VLD,
   output logic               RF_WrEn,
   output logic               RF_RdEn,
   output logic [AddrW-1:0]   RF_Address,
   output logic [Width-1:0]   RF_WrData,
   input  logic [Width-1:0]   RF_RdData,
   input  logic               RF_RdData_VLD,
   output logic               ALU_EN,
   output logic [3:0]         ALU_FUN,
   input  logic [2*Width-1:0] ALU_OUT,
   input  logic               ALU_OUT_VLD,
   output logic               CLK_GATE_EN,
   output logic [Width-1:0]   TX_P_DATA,
   output logic               TX_D_VLD,
   input  logic               TX_BUSY
);

   localparam logic [Width-1:0] CMD_WR     = Width'(8'hAA);
   localparam logic [Width-1:0] CMD_RD     = Width'(8'hBB);
   localparam logic [Width-1:0] CMD_ALU_OP = Width'(8'hCC);
   localparam logic [Width-1:0] CMD_ALU    = Width'(8'hDD);

   typedef enum logic [3:0] {
      IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT,
      ALU_A, ALU_B, ALU_FN, ALU_WAIT, TX_LO, TX_HI
   } state_t;

   state_t               state_q, state_n;
   logic                 wr_en_q, wr_en_n;
   logic                 rd_en_q, rd_en_n;
   logic [AddrW-1:0]     addr_q, addr_n;
   logic [Width-1:0]     wdata_q, wdata_n;
   logic                 alu_en_q, alu_en_n;
   logic [3:0]           fun_q, fun_n;
   logic                 gate_q, gate_n;
   logic [Width-1:0]     txd_q, txd_n;
   logic                 txv_q, txv_n;
   logic [2*Width-1:0]   res_q, res_n;
   logic                 two_q, two_n;

   // State and every output are registered; reset aborts any transaction.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state_q  <= IDLE;
         wr_en_q  <= 1'b0;
         rd_en_q  <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         alu_en_q <= 1'b0;
         fun_q    <= '0;
         gate_q   <= 1'b0;
         txd_q    <= '0;
         txv_q    <= 1'b0;
         res_q    <= '0;
         two_q    <= 1'b0;
      end else begin
         state_q  <= state_n;
         wr_en_q  <= wr_en_n;
         rd_en_q  <= rd_en_n;
         addr_q   <= addr_n;
         wdata_q  <= wdata_n;
         alu_en_q <= alu_en_n;
         fun_q    <= fun_n;
         gate_q   <= gate_n;
         txd_q    <= txd_n;
         txv_q    <= txv_n;
         res_q    <= res_n;
         two_q    <= two_n;
      end
   end

   // Next-state and next-output decode; strobes default low, data holds.
   always_comb begin
      state_n  = state_q;
      wr_en_n  = 1'b0;
      rd_en_n  = 1'b0;
      alu_en_n = 1'b0;
      addr_n   = addr_q;
      wdata_n  = wdata_q;
      fun_n    = fun_q;
      gate_n   = gate_q;
      txd_n    = txd_q;
      txv_n    = txv_q;
      res_n    = res_q;
      two_n    = two_q;
      case (state_q)
         IDLE: begin
            if (RX_D_VLD) begin
               case (RX_P_DATA)
                  CMD_WR:     state_n = WR_ADDR;
                  CMD_RD:     state_n = RD_ADDR;
                  CMD_ALU_OP: begin
                     state_n = ALU_A;
                     gate_n  = 1'b1;
                  end
                  CMD_ALU:    begin
                     state_n = ALU_FN;
                     gate_n  = 1'b1;
                  end
                  default:    state_n = IDLE;
               endcase
            end
         end
         WR_ADDR: begin
            if (RX_D_VLD) begin
               addr_n  = RX_P_DATA[AddrW-1:0];
               state_n = WR_DATA;
            end
         end
         WR_DATA: begin
            if (RX_D_VLD) begin
               wdata_n = RX_P_DATA;
               wr_en_n = 1'b1;
               state_n = IDLE;
            end
         end
         RD_ADDR: begin
            if (RX_D_VLD) begin
               addr_n  = RX_P_DATA[AddrW-1:0];
               rd_en_n = 1'b1;
               state_n = RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (RF_RdData_VLD) begin
               res_n   = {{Width{1'b0}}, RF_RdData};
               two_n   = 1'b0;
               state_n = TX_LO;
               // Present straight away when TX is free to save a cycle.
               if (!TX_BUSY) begin
                  txv_n = 1'b1;
                  txd_n = RF_RdData;
               end
            end
         end
         ALU_A: begin
            if (RX_D_VLD) begin
               addr_n  = '0;
               wdata_n = RX_P_DATA;
               wr_en_n = 1'b1;
               state_n = ALU_B;
            end
         end
         ALU_B: begin
            if (RX_D_VLD) begin
               addr_n  = AddrW'(1);
               wdata_n = RX_P_DATA;
               wr_en_n = 1'b1;
               state_n = ALU_FN;
            end
         end
         ALU_FN: begin
            if (RX_D_VLD) begin
               fun_n    = RX_P_DATA[3:0];
               alu_en_n = 1'b1;
               state_n  = ALU_WAIT;
            end
         end
         ALU_WAIT: begin
            if (ALU_OUT_VLD) begin
               res_n   = ALU_OUT;
               two_n   = 1'b1;
               gate_n  = 1'b0;
               state_n = TX_LO;
               if (!TX_BUSY) begin
                  txv_n = 1'b1;
                  txd_n = ALU_OUT[Width-1:0];
               end
            end
         end
         TX_LO: begin
            if (txv_q) begin
               if (TX_BUSY) begin
                  txv_n   = 1'b0;
                  state_n = two_q ? TX_HI : IDLE;
               end
            end else if (!TX_BUSY) begin
               txv_n = 1'b1;
               txd_n = res_q[Width-1:0];
            end
         end
         TX_HI: begin
            if (txv_q) begin
               if (TX_BUSY) begin
                  txv_n   = 1'b0;
                  state_n = IDLE;
               end
            end else if (!TX_BUSY) begin
               txv_n = 1'b1;
               txd_n = res_q[2*Width-1:Width];
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign RF_WrEn     = wr_en_q;
   assign RF_RdEn     = rd_en_q;
   assign RF_Address  = addr_q;
   assign RF_WrData   = wdata_q;
   assign ALU_EN      = alu_en_q;
   assign ALU_FUN     = fun_q;
   assign CLK_GATE_EN = gate_q;
   assign TX_P_DATA   = txd_q;
   assign TX_D_VLD    = txv_q;

endmodule
